// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One op in flight; result and rd tag return with a one-cycle done pulse.
module riscv_div_unit #(
    parameter int DATA_W = 32,
    parameter int ALU_OP = 5,
    parameter int ADDR_W = 5,
    parameter logic [ALU_OP-1:0] ALU_DIV  = ALU_OP'(12),
    parameter logic [ALU_OP-1:0] ALU_DIVU = ALU_OP'(13),
    parameter logic [ALU_OP-1:0] ALU_REM  = ALU_OP'(14),
    parameter logic [ALU_OP-1:0] ALU_REMU = ALU_OP'(15)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ALU_OP-1:0] op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic [ADDR_W-1:0] rd_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_result;
    logic [ADDR_W-1:0]   r_rd_o;
    logic [ADDR_W-1:0]   r_rd;
    logic                r_op_rem;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_q;
    logic [DATA_W-1:0]   r_div;
    logic [CNT_W-1:0]    r_count;

    logic                w_is_div;
    logic                w_is_signed;
    logic                w_is_rem;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_abs;
    logic [DATA_W-1:0]   w_b_abs;
    logic                w_div0;
    logic                w_ovf;
    logic                w_special;
    logic [DATA_W-1:0]   w_special_res;
    logic [DATA_W-1:0]   w_rem_sh;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_fix_res;

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;
    assign rd_o     = r_rd_o;

    // Decode the issuing op, magnitudes, special cases and one restoring-divide step
    always_comb begin
        w_is_div    = (op_i == ALU_DIV) || (op_i == ALU_DIVU) ||
                      (op_i == ALU_REM) || (op_i == ALU_REMU);
        w_is_signed = (op_i == ALU_DIV) || (op_i == ALU_REM);
        w_is_rem    = (op_i == ALU_REM) || (op_i == ALU_REMU);
        w_a_neg     = w_is_signed && a_i[DATA_W-1];
        w_b_neg     = w_is_signed && b_i[DATA_W-1];
        w_a_abs     = w_a_neg ? ('0 - a_i) : a_i;
        w_b_abs     = w_b_neg ? ('0 - b_i) : b_i;
        w_div0      = (b_i == '0);
        w_ovf       = w_is_signed && (a_i == {1'b1, {(DATA_W-1){1'b0}}}) && (b_i == '1);
        w_special   = w_div0 || w_ovf;
        if (w_div0)
            w_special_res = w_is_rem ? a_i : '1;
        else
            w_special_res = w_is_rem ? '0 : a_i;

        // Partial remainder stays below 2^(DATA_W-1) before each shift, so no bit is lost
        w_rem_sh = {r_rem[DATA_W-2:0], r_q[DATA_W-1]};
        w_diff   = {1'b0, w_rem_sh} - {1'b0, r_div};

        if (r_op_rem)
            w_fix_res = r_neg_r ? ('0 - r_rem) : r_rem;
        else
            w_fix_res = r_neg_q ? ('0 - r_q) : r_q;
    end

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_o   <= '0;
            r_rd     <= '0;
            r_op_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_q      <= '0;
            r_div    <= '0;
            r_count  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE shares the accept path with IDLE so back-to-back issue works
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush_i && start_i && w_is_div) begin
                        r_busy   <= 1'b1;
                        r_rd     <= rd_i;
                        r_op_rem <= w_is_rem;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_rd_o   <= rd_i;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= w_a_abs;
                            r_div   <= w_b_abs;
                            r_count <= CNT_W'(DATA_W);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (!w_diff[DATA_W]) begin
                            r_rem <= w_diff[DATA_W-1:0];
                            r_q   <= {r_q[DATA_W-2:0], 1'b1};
                        end else begin
                            r_rem <= w_rem_sh;
                            r_q   <= {r_q[DATA_W-2:0], 1'b0};
                        end
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_result <= w_fix_res;
                        r_rd_o   <= r_rd;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Self-checking bench for riscv_div_unit: per-cycle comparison against a
// transaction-level model (expected result, tag and completion edge per op).
module tb_riscv_div_unit;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_DIV  = 5'd12;
    localparam logic [4:0] OP_DIVU = 5'd13;
    localparam logic [4:0] OP_REM  = 5'd14;
    localparam logic [4:0] OP_REMU = 5'd15;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic [4:0]  rd_out;

    riscv_div_unit #(
        .DATA_W   (32),
        .ALU_OP   (5),
        .ADDR_W   (5),
        .ALU_DIV  (OP_DIV),
        .ALU_DIVU (OP_DIVU),
        .ALU_REM  (OP_REM),
        .ALU_REMU (OP_REMU)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .rd_i     (rd),
        .flush_i  (flush),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (res),
        .rd_o     (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          accept;
        int          done_at;
        bit          killed;
        logic [31:0] res;
        logic [4:0]  rd;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    int          free_edge = 0;
    int          reset_at = -1;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    function automatic bit is_divop(logic [4:0] o);
        return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
    endfunction

    // RISC-V M-extension result rules
    function automatic logic [31:0] ref_res(logic [4:0] o, logic [31:0] x, logic [31:0] y);
        int signed sx;
        int signed sy;
        bit        ovf;
        sx  = $signed(x);
        sy  = $signed(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OP_REMU: return (y == 0) ? x : x % y;
            OP_DIV:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
            OP_REM:  return (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
            default: return 32'h0;
        endcase
    endfunction

    // Edges from accept to the edge raising done
    function automatic int lat(logic [4:0] o, logic [31:0] x, logic [31:0] y);
        bit sgn;
        sgn = (o == OP_DIV) || (o == OP_REM);
        if (y == 0 || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))
            return 0;
        return 33;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Per-cycle compare against the model, 1ns after each rising edge
    initial begin
        bit exp_busy;
        bit exp_done;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == reset_at) begin
                last_res = '0;
                last_rd  = '0;
            end
            exp_busy = 1'b0;
            exp_done = 1'b0;
            foreach (q[i])
                if (q[i].accept <= cyc && cyc <= q[i].done_at)
                    exp_busy = 1'b1;
            if (q.size() > 0 && !q[0].killed && q[0].done_at == cyc) begin
                exp_done = 1'b1;
                last_res = q[0].res;
                last_rd  = q[0].rd;
            end
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("done", {31'b0, done}, {31'b0, exp_done});
            check("result", res, last_res);
            check("rd", {27'b0, rd_out}, {27'b0, last_rd});
            while (q.size() > 0 && q[0].done_at <= cyc)
                void'(q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_free();
        while (cyc + 1 < free_edge)
            @(negedge clk);
    endtask

    task automatic push_op(logic [4:0] o, logic [31:0] x, logic [31:0] y, logic [4:0] r);
        ent_t e;
        e.accept  = cyc + 1;
        e.done_at = e.accept + lat(o, x, y);
        e.killed  = 1'b0;
        e.res     = ref_res(o, x, y);
        e.rd      = r;
        q.push_back(e);
        free_edge = e.done_at + 1;
    endtask

    task automatic issue(logic [4:0] o, logic [31:0] x, logic [31:0] y, logic [4:0] r);
        wait_free();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        rd    = r;
        if (is_divop(o))
            push_op(o, x, y, r);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Kill the in-flight op at the upcoming edge, via flush or reset
    task automatic kill_current(bit use_reset, int edge_in_calc);
        int acc;
        acc = q[q.size()-1].accept;
        while (cyc < acc + edge_in_calc - 1)
            @(negedge clk);
        if (use_reset) begin
            rst_n    = 1'b0;
            reset_at = cyc + 1;
        end else begin
            flush = 1'b1;
        end
        q[q.size()-1].done_at = cyc;
        q[q.size()-1].killed  = 1'b1;
        free_edge = cyc + 2;
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
    endtask

    initial begin
        logic [4:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          done_cnt;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        rd    = '0;

        // Hand-computed literals pinning the reference model
        check("pin_divu", ref_res(OP_DIVU, 32'd100, 32'd7), 32'd14);
        check("pin_remu", ref_res(OP_REMU, 32'd100, 32'd7), 32'd2);
        check("pin_div_neg", ref_res(OP_DIV, -32'sd7, 32'd2), 32'hFFFF_FFFD);
        check("pin_rem_neg", ref_res(OP_REM, -32'sd7, 32'd2), 32'hFFFF_FFFF);
        check("pin_rem_pos", ref_res(OP_REM, 32'd7, -32'sd2), 32'd1);
        check("pin_divu_ff", ref_res(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'd1);
        check("pin_div0", ref_res(OP_DIV, 32'h1234, 32'd0), 32'hFFFF_FFFF);
        check("pin_rem0", ref_res(OP_REM, 32'h1234, 32'd0), 32'h1234);
        check("pin_ovf_div", ref_res(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("pin_ovf_rem", ref_res(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
        check("pin_lat", 32'(lat(OP_DIVU, 32'd100, 32'd7) + 1), 32'd34);
        check("pin_lat_spc", 32'(lat(OP_REM, 32'h1234, 32'd0)), 32'd0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
        issue(OP_REMU, 32'd100, 32'd7, 5'd6);
        issue(OP_DIV, -32'sd7, 32'd2, 5'd7);
        issue(OP_REM, -32'sd7, 32'd2, 5'd8);
        issue(OP_REM, 32'd7, -32'sd2, 5'd9);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
        issue(OP_DIV, 32'h1234, 32'd0, 5'd11);
        issue(OP_REM, 32'h1234, 32'd0, 5'd12);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        issue(OP_REMU, 32'h55, 32'd0, 5'd15);
        issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

        // start held through CALC with new operands: second op accepted leaving DONE
        wait_free();
        start = 1'b1;
        op = OP_DIV; a = 32'd1000; b = -32'sd3; rd = 5'd17;
        push_op(OP_DIV, 32'd1000, -32'sd3, 5'd17);
        @(negedge clk);
        op = OP_REMU; a = 32'd12345; b = 32'd100; rd = 5'd18;
        begin
            ent_t e2;
            e2.accept  = q[q.size()-1].done_at + 1;
            e2.done_at = e2.accept + lat(OP_REMU, 32'd12345, 32'd100);
            e2.killed  = 1'b0;
            e2.res     = ref_res(OP_REMU, 32'd12345, 32'd100);
            e2.rd      = 5'd18;
            q.push_back(e2);
            free_edge = e2.done_at + 1;
            while (cyc < e2.accept)
                @(negedge clk);
        end
        start = 1'b0;

        // Flush at cycle 10 of CALC, then a normal op
        issue(OP_DIVU, 32'd999, 32'd9, 5'd19);
        kill_current(1'b0, 10);
        issue(OP_DIVU, 32'd999, 32'd9, 5'd20);

        // Flush in IDLE beats start
        wait_free();
        start = 1'b1; flush = 1'b1;
        op = OP_DIV; a = 32'd50; b = 32'd5; rd = 5'd21;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;

        // Reset for one edge mid-CALC
        issue(OP_REM, -32'sd1000, 32'd7, 5'd22);
        kill_current(1'b1, 12);

        // Non-divide op is ignored
        issue(OP_ADD, 32'd1, 32'd2, 5'd23);
        issue(OP_DIV, -32'sd77, -32'sd5, 5'd24);

        // Randomized ops
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case ($urandom_range(0, 4))
                0: ro = OP_DIV;
                1: ro = OP_DIVU;
                2: ro = OP_REM;
                3: ro = OP_REMU;
                default: ro = ($urandom_range(0, 3) == 0) ? OP_ADD : OP_DIV;
            endcase
            case ($urandom_range(0, 6))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin
                    ra = $urandom_range(0, 500);
                    rb = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                3: begin ra = $urandom; rb = 32'h8000_0000 | $urandom; end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            issue(ro, ra, rb, 5'($urandom_range(0, 31)));
        end

        wait_free();
        repeat (3) @(negedge clk);
        done_cnt = q.size();
        check("queue_drained", 32'(done_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
